// File: rtl/mdu_pkg.sv
// Shared MDU definitions: divide opcodes, divider FSM states and funct3 codes.
// Used by the divider, the multiplier path and the id decoder.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    function automatic logic is_signed_op(input div_op_e op);
        return ~op[0];
    endfunction

    function automatic logic is_rem_op(input div_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_div_unit_if.sv
// Issue/result bundle between exe and the divider.
// master = issuer in exe, slave = mdu_div_unit.
interface mdu_div_if
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            start_i;
    logic            flush_i;
    div_op_e         op_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, flush_i, op_i, dividend_i, divisor_i,
        input  busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, flush_i, op_i, dividend_i, divisor_i,
        output busy_o, valid_o, result_o
    );
endinterface

// File: rtl/mdu_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// MDU_DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module mdu_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    mdu_div_if.slave   bus
);
    localparam int CNT_W = $clog2(XLEN);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    div_op_e          op_q;
    logic             quot_neg;
    logic             rem_neg;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  dvs;
    logic [XLEN-1:0]  result_q;
    logic             valid_q;

    logic            sgn_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            ovf;
    logic            accept;
    logic [XLEN-1:0] special_res;
    logic            early_hit;
    logic [XLEN-1:0] early_res;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    // One restoring step: shift {rem,quo} left, trial-subtract over XLEN+1 bits.
    function automatic logic [2*XLEN-1:0] div_step(
        input logic [XLEN-1:0] r,
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] d
    );
        logic [XLEN:0] shifted;
        logic [XLEN:0] trial;
        shifted = {r, q[XLEN-1]};
        trial   = shifted - {1'b0, d};
        if (trial[XLEN])
            return {shifted[XLEN-1:0], q[XLEN-2:0], 1'b0};
        else
            return {trial[XLEN-1:0], q[XLEN-2:0], 1'b1};
    endfunction

    assign sgn_op   = is_signed_op(bus.op_i);
    assign a_neg    = sgn_op & bus.dividend_i[XLEN-1];
    assign b_neg    = sgn_op & bus.divisor_i[XLEN-1];
    assign a_mag    = a_neg ? -bus.dividend_i : bus.dividend_i;
    assign b_mag    = b_neg ? -bus.divisor_i : bus.divisor_i;
    assign div_zero = (bus.divisor_i == '0);
    assign ovf      = sgn_op
                    & (bus.dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                    & (&bus.divisor_i);
    assign accept   = bus.start_i & ~bus.flush_i
                    & ((state == IDLE) | (state == DONE));

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = is_rem_op(bus.op_i) ? bus.dividend_i : '1;
        else
            special_res = is_rem_op(bus.op_i) ? '0 : bus.dividend_i;
    end

`ifdef MDU_DIV_EARLY_OUT_EN
    assign early_hit = ~div_zero & (a_mag < b_mag);
    assign early_res = is_rem_op(bus.op_i) ? bus.dividend_i : '0;
`else
    assign early_hit = 1'b0;
    assign early_res = '0;
`endif

    assign q_fix = quot_neg ? -quo : quo;
    assign r_fix = rem_neg ? -rem : rem;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= OP_DIV;
            quot_neg <= 1'b0;
            rem_neg  <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else if (bus.flush_i) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    valid_q <= 1'b0;
                    if (accept) begin
                        op_q     <= bus.op_i;
                        quot_neg <= a_neg ^ b_neg;
                        rem_neg  <= a_neg;
                        if (div_zero | ovf) begin
                            state    <= DONE;
                            result_q <= special_res;
                            valid_q  <= 1'b1;
                        end else if (early_hit) begin
                            state    <= DONE;
                            result_q <= early_res;
                            valid_q  <= 1'b1;
                        end else begin
                            state <= CALC;
                            cnt   <= CNT_W'(XLEN - 1);
                            quo   <= a_mag;
                            rem   <= '0;
                            dvs   <= b_mag;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    {rem, quo} <= div_step(rem, quo, dvs);
                    if (cnt == '0)
                        state <= FIX;
                    else
                        cnt <= cnt - 1'b1;
                end
                FIX: begin
                    result_q <= is_rem_op(op_q) ? r_fix : q_fix;
                    valid_q  <= 1'b1;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o   = (state == CALC) | (state == FIX);
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;

endmodule
